merge4to1_rr: RTL

- Four-source to one-sink merge stage with a registered output. It is the collecting end of the 1-to-4 fan-out demultiplexer used in the pipeline.
- Each of four producers offers a word with valid/ready. The block picks one per cycle by round-robin, registers it, and presents it to a single consumer with valid/ready.
- The tag `Sel_out` identifies the originating channel, so the consumer can route the reply back through the demux.

---
 rtl/merge4to1_rr.sv | 75 +++++++
 1 files changed

// File: rtl/merge4to1_rr.sv
// rtl/merge4to1_rr.sv - four-channel round-robin merge with registered output and source tag
module merge4to1_rr #(
    parameter int DATA_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_LENGTH-1:0] Data_in0,
    input  logic [DATA_LENGTH-1:0] Data_in1,
    input  logic [DATA_LENGTH-1:0] Data_in2,
    input  logic [DATA_LENGTH-1:0] Data_in3,
    input  logic [3:0]             Valid_in,
    output logic [3:0]             Ready_out,
    output logic [DATA_LENGTH-1:0] Data_out,
    output logic [1:0]             Sel_out,
    output logic                   Valid_out,
    input  logic                   Ready_in
);

    logic [1:0]             last_grant;
    logic [3:0]             grant;
    logic [1:0]             grant_idx;
    logic                   grant_any;
    logic                   load_en;
    logic [DATA_LENGTH-1:0] grant_data;

    assign load_en = ~Valid_out | Ready_in;

    // Search starts just past the last winner; k=4 wraps back onto last_grant itself.
    always_comb begin
        logic [1:0] idx;
        grant     = 4'b0000;
        grant_idx = 2'd0;
        grant_any = 1'b0;
        idx       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + k[1:0];
            if (!grant_any && Valid_in[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

    always_comb begin
        grant_data = Data_in0;
        case (grant_idx)
            2'd0: grant_data = Data_in0;
            2'd1: grant_data = Data_in1;
            2'd2: grant_data = Data_in2;
            2'd3: grant_data = Data_in3;
            default: grant_data = Data_in0;
        endcase
    end

    assign Ready_out = load_en ? grant : 4'b0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            Valid_out  <= 1'b0;
            Data_out   <= '0;
            Sel_out    <= 2'd0;
            last_grant <= 2'd3;
        end else if (load_en && grant_any) begin
            Valid_out  <= 1'b1;
            Data_out   <= grant_data;
            Sel_out    <= grant_idx;
            last_grant <= grant_idx;
        end else if (Ready_in) begin
            // Drained with nothing new to take; data/tag left as-is.
            Valid_out <= 1'b0;
        end
    end

endmodule
